// File: rtl/apb_prio_cfg_master.sv
// APB requester for the interrupt controller priority table: one transfer per local command, plus an identity-write/readback init run.
// Command to rsp_valid_o is 3 cycles minimum; a single transaction is outstanding, and the response is held until rsp_ready_i.
module apb_prio_cfg_master #(
    parameter int NUM_OF_PERIPHERALS = 16,
    parameter int ADDR_WIDTH         = $clog2(NUM_OF_PERIPHERALS),
    parameter int DATA_WIDTH         = $clog2(NUM_OF_PERIPHERALS),
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_error_o,
    input  logic                  init_start_i,
    output logic                  init_busy_o,
    output logic                  init_done_o,
    output logic                  init_mismatch_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  perror_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OF_PERIPHERALS - 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        RESP    = 3'd3,
        INIT_WR = 3'd4,
        INIT_RD = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_init;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [TW-1:0]         r_tcnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_done;
    logic                  r_mismatch;

    logic                  w_cmd_rdy;
    logic                  w_init_go;
    logic                  w_timeout;
    logic                  w_xfer_end;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_idx_inc;
    logic                  w_mis_set;

    logic                  w_ld;
    logic [ADDR_WIDTH-1:0] w_ld_addr;
    logic                  w_ld_write;
    logic [DATA_WIDTH-1:0] w_ld_wdata;
    logic [ADDR_WIDTH-1:0] w_idx_nxt;
    logic                  w_init_nxt;
    logic                  w_done_nxt;

    // A start request in IDLE wins over a command presented in the same cycle.
    assign w_init_go  = (r_state == IDLE) && init_start_i;
    assign w_cmd_rdy  = prst_i && (r_state == IDLE) && !init_start_i;
    assign w_timeout  = (r_state == ACCESS) && !pready_i && (r_tcnt == TMO_LAST);
    assign w_xfer_end = (r_state == ACCESS) && (pready_i || w_timeout);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_idx_inc  = r_idx + 1'b1;

    // Readback faults only count while init owns the bus; timeout has no pready so it is always a fault.
    assign w_mis_set  = r_init && w_xfer_end &&
                        (w_timeout || perror_i || (!r_pwrite && (prdata_i != DATA_WIDTH'(r_idx))));

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_addr   = r_paddr;
        w_ld_write  = r_pwrite;
        w_ld_wdata  = r_pwdata;
        w_idx_nxt   = r_idx;
        w_init_nxt  = r_init;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_init_go) begin
                    w_state_nxt = INIT_WR;
                    w_ld        = 1'b1;
                    w_ld_addr   = '0;
                    w_ld_write  = 1'b1;
                    w_ld_wdata  = '0;
                    w_idx_nxt   = '0;
                    w_init_nxt  = 1'b1;
                end else if (cmd_valid_i && w_cmd_rdy) begin
                    w_state_nxt = SETUP;
                    w_ld        = 1'b1;
                    w_ld_addr   = cmd_addr_i;
                    w_ld_write  = cmd_write_i;
                    w_ld_wdata  = cmd_wdata_i;
                end
            end

            SETUP, INIT_WR, INIT_RD: begin
                w_state_nxt = ACCESS;
            end

            ACCESS: begin
                if (w_xfer_end) begin
                    if (!r_init) begin
                        w_state_nxt = RESP;
                    end else if (r_pwrite) begin
                        if (w_last) begin
                            w_state_nxt = INIT_RD;
                            w_ld        = 1'b1;
                            w_ld_addr   = '0;
                            w_ld_write  = 1'b0;
                            w_idx_nxt   = '0;
                        end else begin
                            w_state_nxt = INIT_WR;
                            w_ld        = 1'b1;
                            w_ld_addr   = w_idx_inc;
                            w_ld_write  = 1'b1;
                            w_ld_wdata  = DATA_WIDTH'(w_idx_inc);
                            w_idx_nxt   = w_idx_inc;
                        end
                    end else begin
                        if (w_last) begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = '0;
                            w_init_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = INIT_RD;
                            w_ld        = 1'b1;
                            w_ld_addr   = w_idx_inc;
                            w_ld_write  = 1'b0;
                            w_idx_nxt   = w_idx_inc;
                        end
                    end
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            r_init      <= 1'b0;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            r_init <= w_init_nxt;
            r_idx  <= w_idx_nxt;
            r_done <= w_done_nxt;

            if (w_ld) begin
                r_paddr  <= w_ld_addr;
                r_pwrite <= w_ld_write;
                r_pwdata <= w_ld_wdata;
            end

            // Wait-state counter restarts on every ACCESS entry.
            if ((r_state == ACCESS) && !w_xfer_end) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end

            if (w_xfer_end && !r_init) begin
                r_rsp_error <= !pready_i || perror_i;
                r_rsp_rdata <= (pready_i && !r_pwrite) ? prdata_i : '0;
            end

            if (w_init_go) begin
                r_mismatch <= 1'b0;
            end else if (w_mis_set) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign cmd_ready_o     = w_cmd_rdy;
    assign rsp_valid_o     = (r_state == RESP);
    assign rsp_rdata_o     = r_rsp_rdata;
    assign rsp_error_o     = r_rsp_error;
    assign init_busy_o     = r_init;
    assign init_done_o     = r_done;
    assign init_mismatch_o = r_mismatch;
    assign paddr_o         = r_paddr;
    assign pwrite_o        = r_pwrite;
    assign pwdata_o        = r_pwdata;
    assign penable_o       = (r_state == ACCESS);

endmodule

// File: tb/tb_apb_prio_cfg_master.sv
// Randomized bench for apb_prio_cfg_master: an APB slave model answers from a per-transfer plan,
// and a monitor scores responses against expectations queued when each command is issued.
module tb_apb_prio_cfg_master;

    localparam int N   = 16;
    localparam int AW  = 4;
    localparam int DW  = 4;
    localparam int TMO = 16;

    logic          pclk_i = 1'b0;
    logic          prst_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_write_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_error_o;
    logic          init_start_i = 1'b0;
    logic          init_busy_o;
    logic          init_done_o;
    logic          init_mismatch_o;
    logic [AW-1:0] paddr_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic          penable_o;
    logic [DW-1:0] prdata_i = '0;
    logic          pready_i = 1'b0;
    logic          perror_i = 1'b0;

    apb_prio_cfg_master #(
        .NUM_OF_PERIPHERALS(N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk_i(pclk_i), .prst_i(prst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .init_start_i(init_start_i), .init_busy_o(init_busy_o),
        .init_done_o(init_done_o), .init_mismatch_o(init_mismatch_o),
        .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .perror_i(perror_i)
    );

    always #5 pclk_i = ~pclk_i;

    // One entry per APB transfer: what the master must drive, and how the slave answers.
    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            wt;
        logic          er;
        logic [DW-1:0] rdata;
    } apb_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic apb_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                                input int wt, input logic er, input logic [DW-1:0] rd);
        apb_t t;
        t.addr = a; t.wr = w; t.wdata = d; t.wt = wt; t.er = er; t.rdata = rd;
        return t;
    endfunction

    // Command-level reference: a transfer that never sees pready is an error with zero data.
    function automatic rsp_t expect_rsp(input apb_t t);
        rsp_t r;
        if (t.wt >= TMO) begin
            r.err = 1'b1; r.rdata = '0;
        end else begin
            r.err = t.er; r.rdata = t.wr ? '0 : t.rdata;
        end
        return r;
    endfunction

    // APB slave model
    initial begin
        int   k;
        int   exp_len;
        apb_t cur;
        k = 0; exp_len = 0;
        cur = mk('0, 1'b0, '0, 0, 1'b0, '0);
        forever begin
            @(negedge pclk_i);
            if (penable_o && prst_i) begin
                if (k == 0) begin
                    if (apb_q.size() == 0) begin
                        check("apb_spurious", penable_o, 0);
                        cur = mk('0, 1'b0, '0, 0, 1'b0, '0);
                    end else begin
                        cur = apb_q.pop_front();
                        if (cur.wr) check("apb_wdata", pwdata_o, cur.wdata);
                    end
                    exp_len = (cur.wt >= TMO) ? TMO : cur.wt + 1;
                end
                check("apb_addr", paddr_o, cur.addr);
                check("apb_write", pwrite_o, cur.wr);
                pready_i = (k >= cur.wt);
                prdata_i = cur.rdata;
                perror_i = cur.er;
                k++;
            end else begin
                if (k > 0 && prst_i) check("apb_access_len", k, exp_len);
                k = 0; pready_i = 1'b0; perror_i = 1'b0; prdata_i = '0;
            end
        end
    end

    // Response monitor with random backpressure
    initial begin
        rsp_t e;
        forever begin
            @(negedge pclk_i);
            rsp_ready_i = 1'($urandom_range(0, 1));
            if (rsp_q.size() == 0) begin
                if (prst_i) check("rsp_spurious", rsp_valid_o, 0);
            end else if (rsp_valid_o) begin
                e = rsp_q[0];
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_error", rsp_error_o, e.err);
                if (rsp_ready_i) void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int wt, input logic er, input logic [DW-1:0] rd);
        apb_t t;
        int   n;
        t = mk(a, wr, d, wt, er, rd);
        apb_q.push_back(t);
        rsp_q.push_back(expect_rsp(t));
        @(negedge pclk_i);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = d;
        #1;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            @(negedge pclk_i); #1; n++;
        end
        check("cmd_accept", cmd_ready_o, 1);
        @(posedge pclk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < 1000) begin
            @(negedge pclk_i); n++;
        end
        check("drain", rsp_q.size() + apb_q.size(), 0);
    endtask

    task automatic run_init(input int bad_wr, input int bad_rd, input int bad_to, input bit collide);
        logic exp_mis;
        logic [DW-1:0] rd;
        int   n;
        int   viol;
        bit   done_seen;
        apb_t t;
        exp_mis = 1'b0;
        for (int i = 0; i < N; i++) begin
            apb_q.push_back(mk(AW'(i), 1'b1, DW'(i), $urandom_range(0, 2), (i == bad_wr), '0));
            if (i == bad_wr) exp_mis = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            rd = (i == bad_rd) ? '0 : DW'(i);
            if (rd != DW'(i) || i == bad_to) exp_mis = 1'b1;
            apb_q.push_back(mk(AW'(i), 1'b0, '0, (i == bad_to) ? 100 : $urandom_range(0, 2), 1'b0, rd));
        end
        if (collide) begin
            t = mk(4'd6, 1'b1, 4'd5, 1, 1'b0, '0);
            apb_q.push_back(t);
            rsp_q.push_back(expect_rsp(t));
        end
        @(negedge pclk_i); #1;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            @(negedge pclk_i); #1; n++;
        end
        check("init_idle", cmd_ready_o, 1);
        init_start_i = 1'b1;
        if (collide) begin
            cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 4'd6; cmd_wdata_i = 4'd5;
        end
        #1;
        check("init_prio_ready", cmd_ready_o, 0);
        @(posedge pclk_i); #1;
        init_start_i = 1'b0;
        @(negedge pclk_i); #1;
        check("init_busy_rise", init_busy_o, 1);
        check("init_mis_clear", init_mismatch_o, 0);
        n = 0; viol = 0; done_seen = 1'b0;
        while (!done_seen && n < 3000) begin
            @(negedge pclk_i); #1;
            if (init_busy_o && cmd_ready_o) viol++;
            if (init_done_o) done_seen = 1'b1;
            n++;
        end
        check("init_done_seen", done_seen, 1);
        check("init_busy_fall", init_busy_o, 0);
        check("init_mismatch", init_mismatch_o, exp_mis);
        check("init_xfers_left", apb_q.size(), collide ? 1 : 0);
        if (collide) begin
            check("collide_ready_after", cmd_ready_o, 1);
            check("collide_blocked", viol, 0);
            @(posedge pclk_i); #1;
            cmd_valid_i = 1'b0;
        end
        @(negedge pclk_i); #1;
        check("init_done_pulse", init_done_o, 0);
        check("init_mis_sticky", init_mismatch_o, exp_mis);
        drain();
    endtask

    initial begin
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        logic          er;
        int            wt;
        int            n;

        // Reset values
        #3;
        check("rst_cmd_ready", cmd_ready_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_busy", init_busy_o, 0);
        check("rst_mismatch", init_mismatch_o, 0);
        check("rst_paddr", paddr_o, 0);
        @(negedge pclk_i); @(negedge pclk_i);
        prst_i = 1'b1;
        #1;
        check("rst_release_ready", cmd_ready_o, 1);

        // Directed write: SETUP/ACCESS phases and 3-cycle latency
        issue(1'b1, 4'd3, 4'd7, 0, 1'b0, '0);
        @(negedge pclk_i);
        check("wr_setup_penable", penable_o, 0);
        check("wr_setup_paddr", paddr_o, 3);
        check("wr_setup_pwrite", pwrite_o, 1);
        check("wr_lat_c1", rsp_valid_o, 0);
        @(negedge pclk_i);
        check("wr_access_penable", penable_o, 1);
        check("wr_access_pwdata", pwdata_o, 7);
        check("wr_lat_c2", rsp_valid_o, 0);
        @(negedge pclk_i);
        check("wr_lat_c3", rsp_valid_o, 1);
        drain();

        // Read with 4 wait states, then a timeout
        issue(1'b0, 4'd5, 4'd0, 4, 1'b0, 4'd9);
        drain();
        issue(1'b0, 4'd12, 4'd0, 100, 1'b0, 4'd9);
        drain();

        // Random commands
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            er = ($urandom_range(0, 3) == 0);
            wt = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 5);
            issue(wr, a, d, wt, er, rd);
        end
        drain();

        // Init: clean, faulty, and colliding with a command
        run_init(-1, -1, -1, 1'b0);
        run_init(2, 10, 13, 1'b0);
        run_init(7, -1, -1, 1'b1);

        // Reset in the middle of ACCESS
        issue(1'b0, 4'd9, 4'd0, 100, 1'b0, 4'd0);
        n = 0;
        while (!penable_o && n < 20) begin
            @(negedge pclk_i); n++;
        end
        check("rst_reach_access", penable_o, 1);
        #2;
        prst_i = 1'b0;
        apb_q.delete();
        rsp_q.delete();
        #1;
        check("midrst_penable", penable_o, 0);
        check("midrst_cmd_ready", cmd_ready_o, 0);
        check("midrst_rsp_valid", rsp_valid_o, 0);
        check("midrst_mismatch", init_mismatch_o, 0);
        check("midrst_paddr", paddr_o, 0);
        check("midrst_pwrite", pwrite_o, 0);
        @(negedge pclk_i); @(negedge pclk_i);
        prst_i = 1'b1;
        #1;
        check("midrst_release_ready", cmd_ready_o, 1);
        issue(1'b1, 4'd15, 4'd10, 2, 1'b0, '0);
        issue(1'b0, 4'd15, 4'd0, 1, 1'b0, 4'd10);
        drain();

        repeat (3) @(negedge pclk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_prio_cfg_master.md
Name: apb_prio_cfg_master

Overview:
- APB-style requester that drives the interrupt controller's programming port: paddr/pwrite/pwdata/penable out, prdata/pready/perror in.
- Accepts single read/write commands from a local command port and issues one APB transfer per command.
- Also runs a self-contained init sequence: it writes an identity priority table (register i = i) to every register, then reads each back and flags any mismatch.
- Sits between a configuration source (CPU shim or test sequencer) and the interrupt controller's register file.

Parameters:
- NUM_OF_PERIPHERALS, 16, number of priority registers (one per peripheral).
- ADDR_WIDTH, $clog2(NUM_OF_PERIPHERALS), APB address width.
- DATA_WIDTH, $clog2(NUM_OF_PERIPHERALS), APB data width (holds one priority value).
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles without pready_i before the master aborts; must be ≥1.

Ports:
- pclk_i  in  1  clock.
- prst_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target register.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes).
- rsp_error_o  out  1  perror_i seen or timeout.
- init_start_i  in  1  one-cycle pulse; starts the init sequence.
- init_busy_o  out  1  init sequence in progress.
- init_done_o  out  1  one-cycle pulse when init completes.
- init_mismatch_o  out  1  sticky; set on readback mismatch, error or timeout during init; cleared at the next init start.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- penable_o  out  1  APB access phase.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- perror_i  in  1  APB error, sampled with pready_i.

Behaviour:
- Reset (async, prst_i=0):
  - State IDLE.
  - All outputs 0, except cmd_ready_o=1 once prst_i releases.
  - Init index 0; init_mismatch_o cleared.
  - Reset mid-transfer drops penable_o immediately; the transfer and any pending response are lost.
- States: IDLE, SETUP, ACCESS, RESP, INIT_WR, INIT_RD.
- IDLE:
  - cmd_ready_o=1 only in IDLE with init_start_i low.
  - init_start_i has priority over cmd_valid_i in the same cycle: the command is not accepted and cmd_ready_o=0.
  - A command handshake latches addr/write/wdata → SETUP.
- SETUP (exactly 1 cycle): paddr_o/pwrite_o/pwdata_o driven, penable_o=0 → ACCESS.
- ACCESS:
  - penable_o=1; address/data/direction stay stable.
  - Stays until pready_i=1. That cycle captures prdata_i (reads only) and perror_i.
  - In command mode → RESP.
  - Timeout: a counter starts at 0 on ACCESS entry. If it reaches TIMEOUT_CYCLES with no pready_i, the transfer ends with error=1 and rdata=0.
- Latency: the earliest rsp_valid_o is 3 cycles after the command handshake (SETUP, ACCESS with pready_i=1, then RESP).
- RESP:
  - rsp_valid_o=1 with data and error held stable until rsp_ready_i=1 → IDLE.
  - No new command is accepted while in RESP; one transaction is outstanding at most.
- Init sequence:
  - On init_start_i, init_busy_o=1 and init_mismatch_o is cleared.
  - Write phase: for i = 0..NUM_OF_PERIPHERALS-1, SETUP then ACCESS writes with paddr=i, pwdata=i[DATA_WIDTH-1:0].
  - Read phase: the same for reads. A read mismatch (prdata_i≠i), perror_i or a timeout sets init_mismatch_o; the sequence continues to the end regardless.
  - The index wraps from NUM_OF_PERIPHERALS-1 to 0 between phases.
  - On the last read: init_done_o pulses 1 cycle, init_busy_o drops → IDLE.
  - No rsp_valid_o is produced during init; init_start_i while busy is ignored.
- pwrite_o/paddr_o/pwdata_o hold their last value in IDLE; penable_o is 0 outside ACCESS.

Test Plan:
- Write: cmd write addr=3 data=7, pready_i=1 at first ACCESS cycle → SETUP cycle with penable_o=0 and paddr_o=3, then ACCESS with penable_o=1, pwdata_o=7; rsp_valid_o 3 cycles after the handshake, rsp_error_o=0.
- Read with wait states: cmd read addr=5, pready_i held low 4 ACCESS cycles then high with prdata_i=9 → penable_o high for 5 cycles, rsp_rdata_o=9, response held until rsp_ready_i.
- Timeout: cmd read with pready_i tied 0, TIMEOUT_CYCLES=16 → penable_o drops after 16 ACCESS cycles, rsp_error_o=1, rsp_rdata_o=0.
- Init, clean slave model: init_start_i pulse → 16 writes (addr i, data i) then 16 reads, init_done_o pulse after 32 transfers, init_mismatch_o=0.
- Init with a fault: slave returns 0 for addr 10 and asserts perror_i on the write to addr 2 → init_mismatch_o=1, all 32 transfers still issued.
- Collision and reset: cmd_valid_i and init_start_i asserted in the same cycle → init runs and cmd_ready_o=0 until init_busy_o falls. Then prst_i asserted mid-ACCESS → penable_o=0 at once, all outputs at reset values.
